pokey_sio: RTL
==============

POKEY_SIO -- requirements
Module: pokey_sio

Interface
REQ-001 SHALL have parameter BAUD_DIV, default 93: clk_i cycles per serial bit time (legal range 4..65535).
REQ-002 SHALL have port clk_i  in  1  single system clock; all logic on its rising edge.
REQ-003 SHALL have port rst_i  in  1  asynchronous active-high reset.
REQ-004 SHALL have port serout_i  in  8  byte to transmit (from POKEY SEROUT).
REQ-005 SHALL have port serout_rdy_i  in  1  transmit byte valid (four-phase request).
REQ-006 SHALL have port serout_ack_o  out  1  transmit byte accepted (four-phase acknowledge).
REQ-007 SHALL have port sio_txd_o  out  1  serial data out, idle high.
REQ-008 SHALL have port sio_rxd_i  in  1  serial data in, asynchronous, idle high.
REQ-009 SHALL have port serin_o  out  8  last received byte.
REQ-010 SHALL have port serin_rdy_o  out  1  received byte valid (four-phase request).
REQ-011 SHALL have port serin_ack_i  in  1  received byte consumed (four-phase acknowledge).
REQ-012 SHALL have port tx_busy_o  out  1  transmitter not in IDLE.
REQ-013 SHALL have port rx_err_o  out  1  one-cycle pulse on framing error or overrun.
REQ-014 SHALL have port loopback_i  in  1  internal loopback request (see Configuration).

Function
REQ-015 SHALL frame bytes as 1 start bit (0), 8 data bits LSB first, 1 stop bit (1), each exactly BAUD_DIV cycles.
REQ-016 TX FSM states SHALL be IDLE, START, DATA, STOP; IDLE->START when serout_rdy_i=1 and serout_ack_o=0, latching serout_i and setting serout_ack_o the same edge.
REQ-017 serout_ack_o SHALL clear on the first edge where serout_rdy_i=0, independent of TX progress.
REQ-018 sio_txd_o SHALL go low on the edge after acceptance (latency 1 cycle); DATA->STOP after bit 7; STOP->IDLE after BAUD_DIV cycles; no new byte accepted while serout_ack_o=1 or state!=IDLE.
REQ-019 sio_rxd_i SHALL pass a 2-flop synchronizer; RX FSM states IDLE, START, DATA, STOP.
REQ-020 RX IDLE->START on synchronized falling edge; at BAUD_DIV/2 (integer) cycles later line re-sampled: 1 -> IDLE (glitch, no error), 0 -> DATA.
REQ-021 Data bits SHALL be sampled every BAUD_DIV cycles after the start-bit midpoint; stop bit sampled one further BAUD_DIV later.
REQ-022 Stop=1 and serin_rdy_o=0: serin_o loaded, serin_rdy_o set the same edge; RX returns to IDLE.
REQ-023 Stop=0: byte discarded, rx_err_o pulsed, serin_o/serin_rdy_o unchanged; RX enters IDLE only once line is 1.
REQ-024 Stop=1 with serin_rdy_o=1 (overrun): new byte discarded, rx_err_o pulsed, old byte kept.
REQ-025 serin_rdy_o SHALL clear on the edge after serin_ack_i=1 is sampled; serin_ack_i while serin_rdy_o=0 SHALL be ignored.
REQ-026 Bit-timer SHALL be 16-bit down-counter per direction; TX and RX fully independent and concurrently active.

Reset
REQ-027 rst_i SHALL asynchronously force: both FSMs IDLE, sio_txd_o=1, serout_ack_o=0, serin_rdy_o=0, serin_o=0x00, tx_busy_o=0, rx_err_o=0, synchronizer flops=1, timers=0.
REQ-028 Reset mid-frame SHALL abort the frame; no partial byte is ever presented after release.

Configuration
REQ-029 Macro POKEY_SIO_LOOPBACK_EN defined: loopback_i=1 routes internal TX bit stream to RX synchronizer input and holds sio_txd_o=1.
REQ-030 Macro undefined: loopback_i ignored, RX always uses sio_rxd_i; port remains present.

Structure
REQ-031 Shared package pokey_sio_pkg SHALL hold the FSM state enum (IDLE/START/DATA/STOP), frame constants (8 data bits, start=0, stop=1), and default BAUD_DIV.
REQ-032 One sub-module pokey_sio_bittimer (load, count, midpoint and end-of-bit strobes) SHALL be instantiated once for TX and once for RX.

Verification (BAUD_DIV=4)
REQ-033 serout_i=0xA5, rdy pulse -> ack 1 cycle later; txd = 0,1,0,1,0,0,1,0,1,1 each 4 cycles; tx_busy_o high 40 cycles.
REQ-034 Drive rxd frame for 0x3C -> serin_o=0x3C, serin_rdy_o=1; serin_ack_i=1 -> serin_rdy_o=0 next edge.
REQ-035 Two rx frames 0x11, 0x22 without ack -> serin_o stays 0x11, rx_err_o one pulse after second stop.
REQ-036 rxd low for 1 cycle only -> no byte, no error; rxd frame with stop=0 -> rx_err_o pulse, serin_rdy_o stays 0.
REQ-037 rst_i asserted at TX bit 3 -> txd=1, tx_busy_o=0 immediately; held serout_rdy_i=1 after release -> new frame starts cleanly.
REQ-038 With POKEY_SIO_LOOPBACK_EN, loopback_i=1, transmit 0x5A -> serin_o=0x5A, sio_txd_o constantly 1.

Source files
------------

// File: rtl/pokey_sio_pkg.sv
// Shared definitions for the POKEY serial I/O bridge: FSM state encoding,
// frame constants and default bit timing.
package pokey_sio_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } sio_state_e;

  localparam int   DATA_BITS        = 8;
  localparam logic START_BIT        = 1'b0;
  localparam logic STOP_BIT         = 1'b1;
  localparam int   DEFAULT_BAUD_DIV = 93;

  // Reload value for a down-counter that must expire after `cycles` clocks.
  function automatic logic [15:0] timer_load(input int cycles);
    return 16'(cycles - 1);
  endfunction

endpackage

// File: rtl/pokey_sio_bittimer.sv
// 16-bit bit-time down-counter. A full load expires after BAUD_DIV cycles
// (end-of-bit strobe), a half load after BAUD_DIV/2 cycles (midpoint strobe).
module pokey_sio_bittimer
  import pokey_sio_pkg::*;
#(
  parameter int BAUD_DIV = DEFAULT_BAUD_DIV
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic load_full_i,
  input  logic load_half_i,
  output logic mid_o,
  output logic end_o
);

  localparam logic [15:0] FULL_LOAD = timer_load(BAUD_DIV);
  localparam logic [15:0] HALF_LOAD = timer_load(BAUD_DIV / 2);

  logic [15:0] cnt_q;
  logic        half_q;
  logic        expired;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q  <= '0;
      half_q <= 1'b0;
    end else if (load_full_i) begin
      cnt_q  <= FULL_LOAD;
      half_q <= 1'b0;
    end else if (load_half_i) begin
      cnt_q  <= HALF_LOAD;
      half_q <= 1'b1;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - 16'd1;
    end
  end

  // The strobes stay high once expired; callers consume them by reloading
  // or by leaving the state that watches them.
  assign expired = (cnt_q == '0);
  assign mid_o   = expired & half_q;
  assign end_o   = expired & ~half_q;

endmodule

// File: rtl/pokey_sio.sv
// POKEY SEROUT/SERIN to async serial bridge: 8N1 framing, independent TX/RX.
// Optional internal loopback is built only with POKEY_SIO_LOOPBACK_EN defined.
module pokey_sio
  import pokey_sio_pkg::*;
#(
  parameter int BAUD_DIV = DEFAULT_BAUD_DIV
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [7:0] serout_i,
  input  logic       serout_rdy_i,
  output logic       serout_ack_o,
  output logic       sio_txd_o,
  input  logic       sio_rxd_i,
  output logic [7:0] serin_o,
  output logic       serin_rdy_o,
  input  logic       serin_ack_i,
  output logic       tx_busy_o,
  output logic       rx_err_o,
  input  logic       loopback_i
);

  localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

  sio_state_e tx_state_q;
  logic [7:0] tx_shift_q;
  logic [2:0] tx_bit_q;
  logic       tx_line_q;
  logic       tx_accept;
  logic       tx_load;
  logic       tx_end;
  logic       tx_mid_unused;

  sio_state_e rx_state_q;
  logic       rx_sync1_q;
  logic       rx_sync2_q;
  logic       rx_prev_q;
  logic [7:0] rx_shift_q;
  logic [2:0] rx_bit_q;
  logic       rx_brk_q;
  logic       rx_fall;
  logic       rx_load_full;
  logic       rx_load_half;
  logic       rx_mid;
  logic       rx_end;
  logic       rx_line;
  logic       lb_active;

`ifdef POKEY_SIO_LOOPBACK_EN
  assign lb_active = loopback_i;
`else
  logic unused_loopback;
  assign unused_loopback = loopback_i;
  assign lb_active       = 1'b0;
`endif

  assign sio_txd_o = tx_line_q | lb_active;
  assign rx_line   = lb_active ? tx_line_q : sio_rxd_i;

  // ---------------------------------------------------------------- TX
  assign tx_accept = (tx_state_q == ST_IDLE) && serout_rdy_i && !serout_ack_o;

  always_comb begin
    tx_load = 1'b0;
    case (tx_state_q)
      ST_IDLE:           tx_load = tx_accept;
      ST_START, ST_DATA: tx_load = tx_end;
      default:           tx_load = 1'b0;
    endcase
  end

  pokey_sio_bittimer #(.BAUD_DIV(BAUD_DIV)) u_tx_timer (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .load_full_i (tx_load),
    .load_half_i (1'b0),
    .mid_o       (tx_mid_unused),
    .end_o       (tx_end)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      tx_state_q   <= ST_IDLE;
      tx_shift_q   <= '0;
      tx_bit_q     <= '0;
      tx_line_q    <= STOP_BIT;
      tx_busy_o    <= 1'b0;
      serout_ack_o <= 1'b0;
    end else begin
      // Line follows the state one cycle behind, so every bit (start
      // included) is on the wire for exactly BAUD_DIV cycles.
      case (tx_state_q)
        ST_START: tx_line_q <= START_BIT;
        ST_DATA:  tx_line_q <= tx_shift_q[0];
        default:  tx_line_q <= STOP_BIT;
      endcase

      if (tx_accept)          serout_ack_o <= 1'b1;
      else if (!serout_rdy_i) serout_ack_o <= 1'b0;

      case (tx_state_q)
        ST_IDLE: begin
          if (tx_accept) begin
            tx_shift_q <= serout_i;
            tx_state_q <= ST_START;
            tx_busy_o  <= 1'b1;
          end
        end
        ST_START: begin
          if (tx_end) begin
            tx_bit_q   <= '0;
            tx_state_q <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (tx_end) begin
            tx_shift_q <= {1'b0, tx_shift_q[7:1]};
            if (tx_bit_q == LAST_BIT) tx_state_q <= ST_STOP;
            else                      tx_bit_q   <= tx_bit_q + 3'd1;
          end
        end
        default: begin
          if (tx_end) begin
            tx_state_q <= ST_IDLE;
            tx_busy_o  <= 1'b0;
          end
        end
      endcase
    end
  end

  // ---------------------------------------------------------------- RX
  assign rx_fall = rx_prev_q & ~rx_sync2_q;

  always_comb begin
    rx_load_full = 1'b0;
    rx_load_half = 1'b0;
    case (rx_state_q)
      ST_IDLE:  rx_load_half = rx_fall;
      ST_START: rx_load_full = rx_mid && !rx_sync2_q;
      ST_DATA:  rx_load_full = rx_end;
      default:  rx_load_full = 1'b0;
    endcase
  end

  pokey_sio_bittimer #(.BAUD_DIV(BAUD_DIV)) u_rx_timer (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .load_full_i (rx_load_full),
    .load_half_i (rx_load_half),
    .mid_o       (rx_mid),
    .end_o       (rx_end)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rx_sync1_q  <= 1'b1;
      rx_sync2_q  <= 1'b1;
      rx_prev_q   <= 1'b1;
      rx_state_q  <= ST_IDLE;
      rx_shift_q  <= '0;
      rx_bit_q    <= '0;
      rx_brk_q    <= 1'b0;
      serin_o     <= '0;
      serin_rdy_o <= 1'b0;
      rx_err_o    <= 1'b0;
    end else begin
      rx_sync1_q <= rx_line;
      rx_sync2_q <= rx_sync1_q;
      rx_prev_q  <= rx_sync2_q;
      rx_err_o   <= 1'b0;

      if (serin_rdy_o && serin_ack_i) serin_rdy_o <= 1'b0;

      case (rx_state_q)
        ST_IDLE: begin
          if (rx_fall) rx_state_q <= ST_START;
        end
        ST_START: begin
          if (rx_mid) begin
            if (rx_sync2_q) begin
              rx_state_q <= ST_IDLE;
            end else begin
              rx_bit_q   <= '0;
              rx_state_q <= ST_DATA;
            end
          end
        end
        ST_DATA: begin
          if (rx_end) begin
            rx_shift_q <= {rx_sync2_q, rx_shift_q[7:1]};
            if (rx_bit_q == LAST_BIT) rx_state_q <= ST_STOP;
            else                      rx_bit_q   <= rx_bit_q + 3'd1;
          end
        end
        default: begin
          // After a framing error, hold here until the line is released so
          // a long break is not mistaken for a new start bit.
          if (rx_brk_q) begin
            if (rx_sync2_q) begin
              rx_brk_q   <= 1'b0;
              rx_state_q <= ST_IDLE;
            end
          end else if (rx_end) begin
            if (rx_sync2_q == STOP_BIT) begin
              if (!serin_rdy_o) begin
                serin_o     <= rx_shift_q;
                serin_rdy_o <= 1'b1;
              end else begin
                rx_err_o <= 1'b1;
              end
              rx_state_q <= ST_IDLE;
            end else begin
              rx_err_o <= 1'b1;
              rx_brk_q <= 1'b1;
            end
          end
        end
      endcase
    end
  end

endmodule
